// File: rtl/adc128s022_pkg.sv
// ADC128S022 shared constants, FSM encoding and frame helpers (also used by the master).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc128s022_pkg;

  // Frame geometry as seen on the wire
  localparam int ADC_FRAME_BITS      = 16;
  localparam int ADC_LEAD_ZEROS      = 4;
  localparam int ADC_ADDR_FIRST_EDGE = 3;   // 1-based rising edge carrying ADD2
  localparam int ADC_DATA_W          = 12;
  localparam int ADC_NUM_CH          = 8;
  localparam int ADC_ADDR_W          = 3;
  localparam int ADC_CNT_W           = 4;   // counts 16 rising edges, wraps on the last

  // Frame FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } adc_state_e;

  // True when the rising edge following 'cnt' completed edges carries an address bit
  function automatic logic adc_addr_edge(input logic [ADC_CNT_W-1:0] cnt);
    int c;
    c = int'(cnt);
    return (c >= ADC_ADDR_FIRST_EDGE - 1) && (c < ADC_ADDR_FIRST_EDGE - 1 + ADC_ADDR_W);
  endfunction

endpackage

// File: rtl/adc128s022_responder_if.sv
// ADC128S022 serial pins plus channel-table host port and frame status.
// Latency: n/a (wiring only).
// Backpressure: none; the serial side is paced entirely by the master's SCLK.
interface adc128s022_responder_if;
  import adc128s022_pkg::*;

  // Serial side
  logic                   adc_csn;
  logic                   adc_sclk;
  logic                   adc_saddr;
  logic                   adc_sdat;
  logic                   adc_sdat_oe;

  // Host channel-table write port
  logic                   CH_WE;
  logic [ADC_ADDR_W-1:0]  CH_SEL;
  logic [ADC_DATA_W-1:0]  CH_DATA;

  // Frame status
  logic                   FRAME_DONE;
  logic                   FRAME_ERR;
  logic [ADC_ADDR_W-1:0]  LAST_ADDR;

  // Harness side: drives the ADC pins and the table, observes results
  modport master (
    output adc_csn, adc_sclk, adc_saddr, CH_WE, CH_SEL, CH_DATA,
    input  adc_sdat, adc_sdat_oe, FRAME_DONE, FRAME_ERR, LAST_ADDR
  );

  // Responder side
  modport slave (
    input  adc_csn, adc_sclk, adc_saddr, CH_WE, CH_SEL, CH_DATA,
    output adc_sdat, adc_sdat_oe, FRAME_DONE, FRAME_ERR, LAST_ADDR
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses.
// Latency: pulse asserted STAGES cycles after the input change, held for one cycle.
// Backpressure: none.
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_q;

  assign w_q = r_sync[STAGES-1];

  // Synchronizer chain plus one history flop; reset to the idle level so no edge fires on release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= w_q;
    end
  end

  assign o_rise = w_q & ~r_prev;
  assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/adc128s022_responder.sv
// ADC128S022 slave model: returns 12-bit table words on DOUT, captures next-frame address from DIN.
// Latency: SYNC_STAGES+1 CLK cycles from a pin change to the resulting action/output change.
// Backpressure: none; master must keep SCLK phases and CS setup >= SYNC_STAGES+3 CLK cycles.
module adc128s022_responder
  import adc128s022_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = ADC_DATA_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  adc128s022_responder_if.slave   bus
);

  // Synchronized edge events
  logic w_csn_fall;
  logic w_csn_rise;
  logic w_sclk_rise;
  logic w_sclk_fall;

  // DIN only needs a clean level, sampled on detected SCLK rises
  logic [SYNC_STAGES-1:0] r_saddr_sync;
  logic                   w_saddr;

  // FSM
  adc_state_e r_state;
  adc_state_e w_state_nxt;
  logic       w_start;       // frame begins: snapshot the table
  logic       w_last_edge;   // 16th rising edge: frame completes
  logic       w_abort;       // CS released early

  // Datapath
  logic [DATA_W-1:0]          r_table [ADC_NUM_CH];
  logic [ADC_ADDR_W-1:0]      r_conv_addr;
  logic [ADC_ADDR_W-1:0]      r_last_addr;
  logic [ADC_ADDR_W-1:0]      r_addr_sh;
  logic [ADC_FRAME_BITS-1:0]  r_shift;
  logic [ADC_CNT_W-1:0]       r_bit_cnt;
  logic                       r_frame_done;
  logic                       r_frame_err;
  logic                       w_in_shift;

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_csn_sync (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (bus.adc_csn),
    .o_rise (w_csn_rise),
    .o_fall (w_csn_fall)
  );

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sclk_sync (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (bus.adc_sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // DIN synchronizer, same depth as SCLK so address bits line up with the detected rise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_saddr_sync <= '0;
    end else begin
      r_saddr_sync <= {r_saddr_sync[SYNC_STAGES-2:0], bus.adc_saddr};
    end
  end

  assign w_saddr = r_saddr_sync[SYNC_STAGES-1];

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and frame event decode
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last_edge = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_csn_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_sclk_rise && (r_bit_cnt == ADC_CNT_W'(ADC_FRAME_BITS - 1))) begin
          // CS released on the same cycle as the 16th edge still counts as complete,
          // but must go straight to IDLE or DONE would wait for a rise already seen
          w_last_edge = 1'b1;
          w_state_nxt = w_csn_rise ? ST_IDLE : ST_DONE;
        end else if (w_csn_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (w_csn_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_in_shift = (r_state == ST_SHIFT);

  // Channel table: host writes always land, even in the snapshot cycle (snapshot reads the old value)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ADC_NUM_CH; i++) begin
        r_table[i] <= '0;
      end
    end else if (bus.CH_WE) begin
      r_table[bus.CH_SEL] <= bus.CH_DATA;
    end
  end

  // Frame datapath: DOUT shifter, edge counter, DIN address capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_addr_sh <= '0;
    end else if (w_start) begin
      r_shift   <= {{ADC_LEAD_ZEROS{1'b0}}, r_table[r_conv_addr]};
      r_bit_cnt <= '0;
      r_addr_sh <= '0;
    end else if (w_in_shift) begin
      if (w_sclk_rise) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (adc_addr_edge(r_bit_cnt)) begin
          r_addr_sh <= {r_addr_sh[ADC_ADDR_W-2:0], w_saddr};
        end
      end
      if (w_sclk_fall) begin
        r_shift <= {r_shift[ADC_FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // Frame results: next conversion channel, reported address and status pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_conv_addr  <= '0;
      r_last_addr  <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= w_last_edge;
      r_frame_err  <= w_abort;
      if (w_last_edge) begin
        r_conv_addr <= r_addr_sh;
        r_last_addr <= r_addr_sh;
      end
    end
  end

  // Pin drive: DOUT only carries data while shifting; the enable models high-Z outside a frame
  assign bus.adc_sdat    = w_in_shift & r_shift[ADC_FRAME_BITS-1];
  assign bus.adc_sdat_oe = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign bus.FRAME_DONE  = r_frame_done;
  assign bus.FRAME_ERR   = r_frame_err;
  assign bus.LAST_ADDR   = r_last_addr;

endmodule

// File: tb/tb_adc128s022_responder.sv
// Scoreboard bench for adc128s022_responder: an SPI master task drives frames,
// expected words and frame events are queued, independent monitors pop and compare.
module tb_adc128s022_responder;
  import adc128s022_pkg::*;

  localparam int SYNC     = 2;
  localparam int HALF     = 8;          // SCLK phase length in CLK cycles
  localparam int GAP      = 12;
  localparam int GAP_MIN  = SYNC + 3;
  localparam int END_NORM = 0;
  localparam int END_SIM  = 1;          // CS rises together with the last SCLK rise
  localparam int END_RST  = 2;          // RST asserted after the last SCLK rise

  typedef struct {
    bit         is_err;
    logic [2:0] addr;
  } evt_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  adc128s022_responder_if bus();

  adc128s022_responder #(
    .SYNC_STAGES (SYNC),
    .DATA_W      (12)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  evt_t        evt_q[$];
  logic [15:0] word_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic host_write(input logic [2:0] sel, input logic [11:0] dat);
    bus.CH_WE   = 1'b1;
    bus.CH_SEL  = sel;
    bus.CH_DATA = dat;
    wait_cyc(1);
    bus.CH_WE   = 1'b0;
  endtask

  // One CS window; saddr is driven high on non-address edges so misplaced capture shows up
  task automatic frame(input logic [2:0] addr, input int n_rise, input int mode,
                       input bit we_snap, input logic [11:0] we_dat, input int gap);
    bus.adc_csn = 1'b0;
    if (we_snap) begin
      // csn_fall is detected in the cycle after SYNC clock edges
      wait_cyc(SYNC);
      host_write(3'd0, we_dat);
      wait_cyc(HALF - SYNC - 1);
    end else begin
      wait_cyc(HALF);
    end
    for (int e = 1; e <= n_rise; e++) begin
      bus.adc_sclk  = 1'b0;
      bus.adc_saddr = (e >= 3 && e <= 5) ? addr[5-e] : 1'b1;
      wait_cyc(HALF);
      bus.adc_sclk = 1'b1;
      if (mode == END_SIM && e == n_rise) bus.adc_csn = 1'b1;
      wait_cyc(HALF);
    end
    if (mode == END_RST) begin
      RST = 1'b1;
      #1;
      chk("midrst_sdat", 32'(bus.adc_sdat), 32'd0);
      chk("midrst_oe", 32'(bus.adc_sdat_oe), 32'd0);
      chk("midrst_done", 32'(bus.FRAME_DONE), 32'd0);
      chk("midrst_err", 32'(bus.FRAME_ERR), 32'd0);
      chk("midrst_last_addr", 32'(bus.LAST_ADDR), 32'd0);
      bus.adc_csn  = 1'b1;
      bus.adc_sclk = 1'b1;
      wait_cyc(4);
      RST = 1'b0;
      wait_cyc(gap);
    end else begin
      bus.adc_csn = 1'b1;
      wait_cyc(gap);
    end
  endtask

  task automatic push_frame(input logic [15:0] word, input logic [2:0] addr);
    evt_t ev;
    ev.is_err = 1'b0;
    ev.addr   = addr;
    word_q.push_back(word);
    evt_q.push_back(ev);
  endtask

  task automatic push_err();
    evt_t ev;
    ev.is_err = 1'b1;
    ev.addr   = 3'd0;
    evt_q.push_back(ev);
  endtask

  // Frame status monitor
  always @(negedge CLK) begin
    evt_t e;
    if (!RST && (bus.FRAME_DONE || bus.FRAME_ERR)) begin
      if (evt_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_evt: done=%0b err=%0b, no event expected at %0t",
                 bus.FRAME_DONE, bus.FRAME_ERR, $time);
      end else begin
        e = evt_q.pop_front();
        chk("evt_done", 32'(bus.FRAME_DONE), 32'(!e.is_err));
        chk("evt_err", 32'(bus.FRAME_ERR), 32'(e.is_err));
        if (!e.is_err) chk("last_addr", 32'(bus.LAST_ADDR), 32'(e.addr));
      end
    end
  end

  // Output-enable monitor: settled CS level must be reflected by adc_sdat_oe
  int cs_hi = 0;
  int cs_lo = 0;
  always @(negedge CLK) begin
    if (bus.adc_csn) begin
      cs_hi++;
      cs_lo = 0;
    end else begin
      cs_lo++;
      cs_hi = 0;
    end
    if (!RST && cs_hi > SYNC + 1) chk("oe_cs_high", 32'(bus.adc_sdat_oe), 32'd0);
    if (!RST && cs_lo > SYNC + 1) chk("oe_cs_low", 32'(bus.adc_sdat_oe), 32'd1);
  end

  // Serial receive monitor: DOUT sampled just before each SCLK fall
  logic [31:0] rx    = '0;
  int          nbits = 0;

  always @(negedge bus.adc_csn) begin
    rx    = '0;
    nbits = 0;
  end

  always @(negedge bus.adc_sclk) begin
    if (!bus.adc_csn) begin
      rx = {rx[30:0], bus.adc_sdat};
      nbits++;
    end
  end

  always @(posedge bus.adc_csn) begin
    logic [31:0] first16;
    logic [31:0] tail_mask;
    logic [15:0] exp_w;
    if (nbits >= 16) begin
      first16   = (rx >> (nbits - 16)) & 32'hFFFF;
      tail_mask = (32'd1 << (nbits - 16)) - 32'd1;
      if (word_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%0h, no word expected", first16);
      end else begin
        exp_w = word_q.pop_front();
        chk("rx_word", first16, {16'h0, exp_w});
      end
      if (nbits > 16) chk("rx_tail_zero", rx & tail_mask, 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST           = 1'b1;
    bus.adc_csn   = 1'b1;
    bus.adc_sclk  = 1'b1;
    bus.adc_saddr = 1'b0;
    bus.CH_WE     = 1'b0;
    bus.CH_SEL    = '0;
    bus.CH_DATA   = '0;
    wait_cyc(3);
    chk("rst_sdat", 32'(bus.adc_sdat), 32'd0);
    chk("rst_oe", 32'(bus.adc_sdat_oe), 32'd0);
    chk("rst_done", 32'(bus.FRAME_DONE), 32'd0);
    chk("rst_err", 32'(bus.FRAME_ERR), 32'd0);
    chk("rst_last_addr", 32'(bus.LAST_ADDR), 32'd0);
    RST = 1'b0;
    wait_cyc(4);

    host_write(3'd0, 12'hABC);
    host_write(3'd5, 12'h123);

    // First frame returns channel 0; address 5 queued for the next
    push_frame(16'h0ABC, 3'd5);
    frame(3'd5, 16, END_NORM, 1'b0, 12'h0, GAP);
    push_frame(16'h0123, 3'd0);
    frame(3'd0, 16, END_NORM, 1'b0, 12'h0, GAP);

    // Aborted frame leaves conv_addr at 0
    push_err();
    frame(3'd3, 8, END_NORM, 1'b0, 12'h0, GAP);
    push_frame(16'h0ABC, 3'd5);
    frame(3'd5, 16, END_NORM, 1'b0, 12'h0, GAP);

    // Over-long frame: one DONE, trailing bits zero
    push_frame(16'h0123, 3'd0);
    frame(3'd0, 20, END_NORM, 1'b0, 12'h0, GAP);

    // Write to the snapshot channel in the csn_fall detect cycle, then back-to-back frame
    host_write(3'd0, 12'hFFF);
    push_frame(16'h0FFF, 3'd5);
    frame(3'd5, 16, END_NORM, 1'b1, 12'h555, GAP_MIN);
    wait_cyc(0);
    host_write(3'd5, 12'h0AA);
    push_frame(16'h00AA, 3'd0);
    frame(3'd0, 16, END_NORM, 1'b0, 12'h0, GAP_MIN);
    push_frame(16'h0555, 3'd5);
    frame(3'd5, 16, END_NORM, 1'b0, 12'h0, GAP);

    // Reset after edge 9: table cleared, conv_addr back to 0
    frame(3'd6, 9, END_RST, 1'b0, 12'h0, GAP);
    host_write(3'd0, 12'h321);
    host_write(3'd1, 12'h9A5);
    host_write(3'd3, 12'h0F0);
    host_write(3'd5, 12'h654);
    push_frame(16'h0321, 3'd1);
    frame(3'd1, 16, END_NORM, 1'b0, 12'h0, GAP);

    // CS release coincident with the 16th rise is a completed frame
    push_frame(16'h09A5, 3'd3);
    frame(3'd3, 16, END_SIM, 1'b0, 12'h0, GAP);
    push_frame(16'h00F0, 3'd0);
    frame(3'd0, 16, END_NORM, 1'b0, 12'h0, GAP);

    wait_cyc(10);
    chk("evt_q_drained", 32'(evt_q.size()), 32'd0);
    chk("word_q_drained", 32'(word_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc128s022_responder.md
# adc128s022_responder

Synthesizable slave-side model of the ADC128S022 serial interface: it watches `adc_csn`/`adc_sclk`/`adc_saddr` driven by the SPI-style ADC master and returns 12-bit conversion words on `adc_sdat`. Eight channel values are loaded by a host port. The block sits in the simulation and loop-back test harness in place of the physical ADC, so the master and downstream logic run against known data on the FPGA.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `adc_csn`/`adc_sclk`/`adc_saddr` (≥2).
- `DATA_W`, 12, conversion word width (fixed at 12 for this device; other values unsupported).
- `CLK`  in  1  system clock. One clock domain; all logic on posedge `CLK`.
- `RST`  in  1  asynchronous, active-high reset.
- `adc_csn`  in  1  chip select from master, active low, asynchronous to `CLK`.
- `adc_sclk`  in  1  serial clock from master, idles high, asynchronous to `CLK`.
- `adc_saddr`  in  1  serial address (DIN) from master.
- `adc_sdat`  out  1  serial data (DOUT) to master.
- `adc_sdat_oe`  out  1  high while a frame is active (models DOUT high-Z when CS is high).
- `CH_WE`  in  1  write strobe for channel value table.
- `CH_SEL`  in  3  channel index for write.
- `CH_DATA`  in  12  channel value for write.
- `FRAME_DONE`  out  1  one-cycle pulse: frame of 16 rising SCLK edges completed.
- `FRAME_ERR`  out  1  one-cycle pulse: CS deasserted before the 16th rising edge.
- `LAST_ADDR`  out  3  address captured in the most recent completed frame.

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edge detect on the synchronized signals gives `csn_fall`, `csn_rise`, `sclk_rise`, `sclk_fall`.
- Channel table: 8×12 registers, reset 0. Written on `CH_WE` from `CH_SEL`/`CH_DATA`.
- `conv_addr` register, reset 0: the channel converted in the next frame.
- FSM states:
  - IDLE: on `csn_fall`, go to SHIFT. Snapshot `table[conv_addr]` into the 16-bit shift register as {4'b0, value}. Clear edge counter `bit_cnt` (4-bit) and the address shift register.
  - SHIFT:
    - On `sclk_rise`, increment `bit_cnt`. On rising edges 3, 4, 5 (1-based), shift in `adc_saddr`, MSB first (ADD2, ADD1, ADD0).
    - On `sclk_fall`, shift DOUT left by one.
    - On the 16th `sclk_rise`, go to DONE, load `conv_addr` and `LAST_ADDR` with the captured address, and pulse `FRAME_DONE`.
    - On `csn_rise` before the 16th edge, go to IDLE, pulse `FRAME_ERR`, and leave `conv_addr`/`LAST_ADDR` unchanged.
  - DONE: drive `adc_sdat`=0 and ignore further SCLK edges. On `csn_rise`, go to IDLE.
- Output drive:
  - `adc_sdat` = shift-register MSB in SHIFT, 0 otherwise.
  - `adc_sdat_oe` = 1 in SHIFT/DONE.
- Bit order on the wire, as seen at the master: 4 zero bits, then DB11..DB0. DB11 is valid after the 4th falling SCLK edge.
- Pipelining matches the real device: data in frame N belongs to the address sent in frame N−1. The first frame after reset returns channel 0.
- Simultaneous events:
  - `CH_WE` to the snapshot channel in the cycle of `csn_fall`: the snapshot takes the old value, and the write lands in the table.
  - `csn_rise` together with the 16th `sclk_rise`: treated as a completed frame (`FRAME_DONE`, no `FRAME_ERR`).

## Timing
- Reset values:
  - `adc_sdat`=0, `adc_sdat_oe`=0, `FRAME_DONE`=0, `FRAME_ERR`=0, `LAST_ADDR`=0.
  - `conv_addr`=0, table all 0, FSM=IDLE.
  - Synchronizer flops: `csn`=1, `sclk`=1, `saddr`=0.
- Reset mid-frame: outputs return to reset values immediately. The next `csn_fall` seen after reset release starts a fresh frame.
- Input-to-action latency: `SYNC_STAGES`+1 `CLK` cycles. Output changes 1 cycle after the detected edge.
- Constraint: SCLK high and low phases each ≥ `SYNC_STAGES`+3 `CLK` cycles; the master runs from a slower clock or a divider. CS setup to the first SCLK fall ≥ the same figure.

## Structure
- Shared package `adc128s022_pkg`:
  - `ADC_FRAME_BITS`=16, `ADC_LEAD_ZEROS`=4, `ADC_ADDR_FIRST_EDGE`=3, `ADC_DATA_W`=12.
  - FSM state encoding (IDLE/SHIFT/DONE).
  - These are shared with the master.
- One sub-module is natural: `sync_edge_detect` (parameterized-depth synchronizer with rise/fall pulses), instantiated for `csn` and `sclk`; `saddr` uses the synchronizer only.

## Test plan
- Reset, load ch0=0xABC, ch5=0x123, run one frame with address 5 → received word 0x0ABC, `FRAME_DONE` pulse, `LAST_ADDR`=5. Next frame with address 0 → received 0x0123.
- Frame aborted after 8 rising edges with address 3 → `FRAME_ERR` pulse, no `FRAME_DONE`. Next full frame returns the previous `conv_addr` channel.
- 20 SCLK cycles in one CS window → `FRAME_DONE` once at edge 16, `adc_sdat`=0 for cycles 17–20.
- `CH_WE` to ch0 (0x555) in the `csn_fall` detect cycle, ch0 previously 0xFFF → frame returns 0xFFF; the following frame returns 0x555.
- `RST` asserted mid-frame (edge 9) → all outputs 0 at once, `conv_addr`=0. Next frame returns ch0.
- `adc_sdat_oe` is 0 whenever CS is high, including back-to-back frames with a minimal CS-high gap.
